// File: rtl/loader_pkg.sv
// Shared types and helpers for the stream-to-RAM loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATHER,
        ST_WRITE,
        ST_VERIFY_RD,
        ST_DONE,
        ST_ERR
    } state_t;

    // Widest word the packer supports; callers cast to and from their own width.
    localparam int MAX_DATA_W = 512;

    function automatic logic [MAX_DATA_W-1:0] insert_byte(
        input logic [MAX_DATA_W-1:0] word,
        input int                    idx,
        input logic [7:0]            byte_val,
        input logic                  big_endian,
        input int                    bpw
    );
        logic [MAX_DATA_W-1:0] w;
        int lane;
        w    = word;
        lane = big_endian ? (bpw - 1 - idx) : idx;
        w[lane*8 +: 8] = byte_val;
        return w;
    endfunction

endpackage

// File: rtl/ram_access_seq.sv
// One handshaked RAM access: holds cs/we/oe until mem_done or timeout,
// then reports completion one cycle later while cs is already low.
module ram_access_seq #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] data_output,
    output logic              cs,
    output logic              we,
    output logic              oe,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_input,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] rdata
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs         <= 1'b0;
            we         <= 1'b0;
            oe         <= 1'b0;
            address    <= '0;
            data_input <= '0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            rdata      <= '0;
            timer      <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            if (cs) begin
                if (mem_done) begin
                    cs    <= 1'b0;
                    we    <= 1'b0;
                    oe    <= 1'b0;
                    done  <= 1'b1;
                    rdata <= data_output;
                end else if (timer == TMR_W'(1)) begin
                    cs      <= 1'b0;
                    we      <= 1'b0;
                    oe      <= 1'b0;
                    timeout <= 1'b1;
                end else begin
                    timer <= timer - TMR_W'(1);
                end
            end else if (req) begin
                cs      <= 1'b1;
                we      <= wr;
                oe      <= !wr;
                address <= req_addr;
                timer   <= TMR_W'(TIMEOUT);
                if (wr) data_input <= req_data;
            end
        end
    end

endmodule

// File: rtl/stream_ram_loader.sv
// Packs a byte stream into words, writes them to consecutive RAM addresses,
// optionally re-reads the image and compares checksums.
module stream_ram_loader
    import loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int VERIFY     = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_input,
    input  logic [DATA_W-1:0] data_output,
    output logic              cs,
    output logic              we,
    output logic              oe,
    input  logic              mem_done,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W-1:0] words_written,
    output logic [DATA_W-1:0] checksum
);
    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    state_t            state;
    logic [ADDR_W-1:0] base_q, count_q, rd_idx, seq_addr;
    logic [DATA_W-1:0] pack_q, next_word, rd_sum, seq_rdata;
    logic [IDX_W-1:0]  idx;
    logic              last_seen, rd_active;
    logic              accept, word_full, load_end, rd_last;
    logic              seq_req, seq_wr, seq_done, seq_timeout;

    always_comb begin
        next_word = DATA_W'(insert_byte(MAX_DATA_W'(pack_q), int'(idx), s_data,
                                        BIG_ENDIAN != 0, BPW));
        accept    = s_valid && s_ready;
        word_full = accept && (s_last || idx == IDX_W'(BPW - 1));
        // Write request fires in the cycle the word completes so cs rises on the next edge.
        seq_req   = word_full || (state == ST_VERIFY_RD && !rd_active);
        seq_wr    = (state == ST_GATHER);
        seq_addr  = base_q + (seq_wr ? words_written : rd_idx);
        load_end  = last_seen || (count_q != '0 && words_written + ADDR_W'(1) == count_q);
        rd_last   = (rd_idx + ADDR_W'(1) == words_written);
    end

    ram_access_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (seq_req),
        .wr          (seq_wr),
        .req_addr    (seq_addr),
        .req_data    (next_word),
        .mem_done    (mem_done),
        .data_output (data_output),
        .cs          (cs),
        .we          (we),
        .oe          (oe),
        .address     (address),
        .data_input  (data_input),
        .done        (seq_done),
        .timeout     (seq_timeout),
        .rdata       (seq_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            base_q        <= '0;
            count_q       <= '0;
            rd_idx        <= '0;
            pack_q        <= '0;
            rd_sum        <= '0;
            idx           <= '0;
            last_seen     <= 1'b0;
            rd_active     <= 1'b0;
            s_ready       <= 1'b0;
            busy          <= 1'b0;
            finished      <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            checksum      <= '0;
        end else if (start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR)) begin
            state         <= ST_GATHER;
            base_q        <= base_addr;
            count_q       <= word_count;
            pack_q        <= '0;
            idx           <= '0;
            last_seen     <= 1'b0;
            s_ready       <= 1'b1;
            busy          <= 1'b1;
            finished      <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            checksum      <= '0;
        end else begin
            case (state)
                ST_GATHER: begin
                    if (word_full) begin
                        pack_q    <= '0;
                        idx       <= '0;
                        last_seen <= s_last;
                        s_ready   <= 1'b0;
                        state     <= ST_WRITE;
                    end else if (accept) begin
                        pack_q <= next_word;
                        idx    <= idx + IDX_W'(1);
                    end
                end
                ST_WRITE: begin
                    if (seq_timeout) begin
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        error    <= 1'b1;
                        state    <= ST_ERR;
                    end else if (seq_done) begin
                        words_written <= words_written + ADDR_W'(1);
                        checksum      <= checksum + data_input;
                        if (!load_end) begin
                            s_ready <= 1'b1;
                            state   <= ST_GATHER;
                        end else if (VERIFY != 0) begin
                            rd_idx    <= '0;
                            rd_sum    <= '0;
                            rd_active <= 1'b0;
                            state     <= ST_VERIFY_RD;
                        end else begin
                            busy     <= 1'b0;
                            finished <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_VERIFY_RD: begin
                    if (seq_req) rd_active <= 1'b1;
                    if (seq_timeout) begin
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        error    <= 1'b1;
                        state    <= ST_ERR;
                    end else if (seq_done) begin
                        rd_active <= 1'b0;
                        rd_sum    <= rd_sum + seq_rdata;
                        rd_idx    <= rd_idx + ADDR_W'(1);
                        if (rd_last) begin
                            busy     <= 1'b0;
                            finished <= 1'b1;
                            if (rd_sum + seq_rdata == checksum) begin
                                state <= ST_DONE;
                            end else begin
                                error <= 1'b1;
                                state <= ST_ERR;
                            end
                        end
                    end
                end
                ST_IDLE, ST_DONE, ST_ERR: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_ram_loader.sv
// Scoreboard bench: a 32-bit big-endian loader and a 16-bit little-endian loader
// share one RAM model; expected writes are queued from a byte-level reference model.
module tb_stream_ram_loader;
    typedef logic [7:0] u8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
    logic [7:0]  s_data = '0;
    logic [31:0] base = '0, word_count = '0;
    logic        sel = 1'b0, stall = 1'b0, corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = '0;

    logic        a_s_ready, a_cs, a_we, a_oe, a_busy, a_finished, a_error, a_mem_done;
    logic [31:0] a_address, a_data_input, a_data_output, a_ww, a_checksum;
    logic        b_s_ready, b_cs, b_we, b_oe, b_busy, b_finished, b_error, b_mem_done;
    logic [31:0] b_address, b_ww;
    logic [15:0] b_data_input, b_data_output, b_checksum;

    initial begin
        a_mem_done = 1'b0; b_mem_done = 1'b0; a_data_output = '0; b_data_output = '0;
    end

    stream_ram_loader #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .VERIFY(1), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && !sel), .base_addr(base), .word_count(word_count),
        .s_valid(s_valid && !sel), .s_last(s_last), .s_data(s_data), .s_ready(a_s_ready),
        .address(a_address), .data_input(a_data_input), .data_output(a_data_output),
        .cs(a_cs), .we(a_we), .oe(a_oe), .mem_done(a_mem_done), .busy(a_busy),
        .finished(a_finished), .error(a_error), .words_written(a_ww), .checksum(a_checksum));

    stream_ram_loader #(.DATA_W(16), .ADDR_W(32), .BIG_ENDIAN(0), .VERIFY(1), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel), .base_addr(base), .word_count(word_count),
        .s_valid(s_valid && sel), .s_last(s_last), .s_data(s_data), .s_ready(b_s_ready),
        .address(b_address), .data_input(b_data_input), .data_output(b_data_output),
        .cs(b_cs), .we(b_we), .oe(b_oe), .mem_done(b_mem_done), .busy(b_busy),
        .finished(b_finished), .error(b_error), .words_written(b_ww), .checksum(b_checksum));

    logic        cur_s_ready, cur_cs, cur_we, cur_oe, cur_busy, cur_finished, cur_error;
    logic [31:0] cur_address, cur_data_in, cur_ww, cur_checksum;
    assign cur_s_ready  = sel ? b_s_ready  : a_s_ready;
    assign cur_cs       = sel ? b_cs       : a_cs;
    assign cur_we       = sel ? b_we       : a_we;
    assign cur_oe       = sel ? b_oe       : a_oe;
    assign cur_busy     = sel ? b_busy     : a_busy;
    assign cur_finished = sel ? b_finished : a_finished;
    assign cur_error    = sel ? b_error    : a_error;
    assign cur_address  = sel ? b_address  : a_address;
    assign cur_data_in  = sel ? {16'h0, b_data_input} : a_data_input;
    assign cur_ww       = sel ? b_ww       : a_ww;
    assign cur_checksum = sel ? {16'h0, b_checksum} : a_checksum;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // RAM model and write monitor: completes accesses after a random delay.
    always @(negedge clk) begin
        a_mem_done = 1'b0;
        b_mem_done = 1'b0;
        if (cur_cs && !stall && $urandom_range(0, 2) != 0) begin
            if (cur_we) begin
                mem[cur_address] = cur_data_in;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected addr=%h data=%h expected no write", cur_address, cur_data_in);
                end else begin
                    chk("wr_addr", cur_address, exp_addr_q.pop_front());
                    chk("wr_data", cur_data_in, exp_data_q.pop_front());
                end
            end else begin
                rd_v = mem.exists(cur_address) ? mem[cur_address] : 32'h0;
                if (corrupt_en && cur_address == corrupt_addr) rd_v[0] = ~rd_v[0];
            end
            if (sel) begin b_mem_done = 1'b1; b_data_output = rd_v[15:0]; end
            else     begin a_mem_done = 1'b1; a_data_output = rd_v; end
        end
    end

    task automatic check_zero(input string nm);
        chk({nm, "_flags"}, {25'h0, cur_s_ready, cur_cs, cur_we, cur_oe, cur_busy, cur_finished, cur_error}, 32'h0);
        chk({nm, "_address"}, cur_address, 32'h0);
        chk({nm, "_data_input"}, cur_data_in, 32'h0);
        chk({nm, "_words_written"}, cur_ww, 32'h0);
        chk({nm, "_checksum"}, cur_checksum, 32'h0);
    endtask

    task automatic do_start(input logic [31:0] base_i, input logic [31:0] wc_i);
        @(negedge clk);
        base = base_i; word_count = wc_i; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ready_busy", {30'h0, cur_s_ready, cur_busy}, 32'h3);
    endtask

    // Offers bytes in order; returns how many were accepted.
    task automatic drive_bytes(input u8 bytes[$], input bit gaps, input int bpw, output int consumed);
        int i = 0, idle = 0, n;
        bit pend = 0;
        n = bytes.size();
        while (i < n && idle < 60) begin
            s_valid = 1'b0; s_last = 1'b0;
            if (!gaps || $urandom_range(0, 2) != 0) begin
                s_valid = 1'b1; s_data = bytes[i]; s_last = (i == n - 1);
            end
            if (s_valid && cur_s_ready) begin
                pend = ((i + 1) % bpw == 0) || (i == n - 1);
                i++; idle = 0;
            end else idle++;
            @(negedge clk);
            if (pend) begin
                chk("cs_we_after_word", {30'h0, cur_cs, cur_we}, 32'h3);
                pend = 0;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        consumed = i;
    endtask

    task automatic run_load(input bit s, input logic [31:0] base_i, input logic [31:0] wc_i,
                            input u8 bytes[$], input bit gaps, input bit stall_i, input bit exp_err);
        int bpw, n, nw_all, nw, consumed_exp, consumed, t;
        logic [31:0] sum, w, mask;
        sel = s; stall = stall_i;
        bpw  = s ? 2 : 4;
        mask = s ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        n = bytes.size();
        nw_all = (n + bpw - 1) / bpw;
        nw = (wc_i != 0 && wc_i < 32'(nw_all)) ? int'(wc_i) : nw_all;
        consumed_exp = (nw < nw_all) ? nw * bpw : n;
        sum = 0;
        mem.delete();
        for (int k = 0; k < nw; k++) begin
            w = 0;
            for (int j = 0; j < bpw; j++)
                if (k * bpw + j < n) w |= 32'(bytes[k * bpw + j]) << (s ? 8 * j : 8 * (bpw - 1 - j));
            sum = (sum + w) & mask;
            if (!stall_i) begin
                exp_addr_q.push_back(base_i + 32'(k));
                exp_data_q.push_back(w);
            end
        end
        if (stall_i) begin nw = 0; sum = 0; end
        do_start(base_i, wc_i);
        drive_bytes(bytes, gaps, bpw, consumed);
        t = 0;
        while (!cur_finished && t < 3000) begin @(negedge clk); t++; end
        chk("finished", {31'h0, cur_finished}, 32'h1);
        chk("error", {31'h0, cur_error}, {31'h0, exp_err});
        chk("words_written", cur_ww, 32'(nw));
        chk("checksum", cur_checksum, sum);
        chk("ready_busy_after", {30'h0, cur_s_ready, cur_busy}, 32'h0);
        chk("bytes_consumed", 32'(consumed), 32'(consumed_exp));
        chk("writes_outstanding", 32'(exp_addr_q.size()), 32'h0);
        exp_addr_q.delete(); exp_data_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        u8 q[$];
        int c;
        repeat (3) @(negedge clk);
        sel = 0; check_zero("reset_a");
        sel = 1; check_zero("reset_b");
        rst_n = 1'b1;

        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(0, 32'h10, 0, q, 0, 0, 0);
        run_load(1, 32'h10, 0, q, 0, 0, 0);
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load(0, 32'h40, 0, q, 0, 0, 0);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(0, 32'h80, 1, q, 0, 0, 0);

        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        corrupt_addr = 32'h11; corrupt_en = 1'b1;
        run_load(0, 32'h10, 0, q, 0, 0, 1);
        corrupt_en = 1'b0;

        for (int r = 0; r < 10; r++) begin
            q.delete();
            c = $urandom_range(1, 12);
            for (int i = 0; i < c; i++) q.push_back(u8'($urandom_range(0, 255)));
            run_load(r % 3 != 0, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFE : $urandom,
                     32'($urandom_range(0, 3)), q, 1, 0, 0);
        end

        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(0, 32'h20, 0, q, 0, 1, 1);

        // Reset in the middle of a stalled write access.
        sel = 0; stall = 1;
        do_start(32'h30, 0);
        drive_bytes(q, 0, 4, c);
        chk("cs_before_reset", {31'h0, cur_cs}, 32'h1);
        #1 rst_n = 1'b0;
        #1 check_zero("mid_reset_a");
        @(negedge clk);
        rst_n = 1'b1; stall = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
